// File: rtl/otter_clint.sv
// otter_clint: memory-mapped mtime/mtimecmp/msip; drives MTIP (bit 7) and MSIP (bit 3).
// Optional mtime prescaler is built when OTTER_CLINT_PRESCALER_EN is defined.
module otter_clint #(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_we,
    input  logic        bus_re,
    output logic [31:0] bus_rdata,
    output logic        bus_rvld,
    output logic        bus_err,
    output logic [31:0] intrpt
);

    localparam logic [15:0] ADDR_MSIP    = 16'h0000;
    localparam logic [15:0] ADDR_CMP_LO  = 16'h4000;
    localparam logic [15:0] ADDR_CMP_HI  = 16'h4004;
    localparam logic [15:0] ADDR_TIME_LO = 16'hBFF8;
    localparam logic [15:0] ADDR_TIME_HI = 16'hBFFC;

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip;

    logic        sel_msip;
    logic        sel_cmp_lo;
    logic        sel_cmp_hi;
    logic        sel_time_lo;
    logic        sel_time_hi;
    logic        legal;
    logic        illegal;
    logic        wr_mtime;
    logic        mtip_next;
    logic        tick;
    logic [31:0] rd_mux;

    // Address decode; every legal address is word aligned by construction.
    always_comb begin
        sel_msip    = (bus_addr == ADDR_MSIP);
        sel_cmp_lo  = (bus_addr == ADDR_CMP_LO);
        sel_cmp_hi  = (bus_addr == ADDR_CMP_HI);
        sel_time_lo = (bus_addr == ADDR_TIME_LO);
        sel_time_hi = (bus_addr == ADDR_TIME_HI);
        legal       = sel_msip | sel_cmp_lo | sel_cmp_hi |
                      sel_time_lo | sel_time_hi;
        illegal     = (bus_we | bus_re) & ~legal;
        wr_mtime    = bus_we & (sel_time_lo | sel_time_hi);
        mtip_next   = (mtime >= mtimecmp);
    end

    // Read mux over pre-write, pre-tick register values.
    always_comb begin
        rd_mux = 32'd0;
        case (1'b1)
            sel_msip:    rd_mux = {31'd0, msip};
            sel_cmp_lo:  rd_mux = mtimecmp[31:0];
            sel_cmp_hi:  rd_mux = mtimecmp[63:32];
            sel_time_lo: rd_mux = mtime[31:0];
            sel_time_hi: rd_mux = mtime[63:32];
            default:     rd_mux = 32'd0;
        endcase
    end

`ifdef OTTER_CLINT_PRESCALER_EN
    localparam logic [31:0] RELOAD =
        (PRESCALE > 1) ? 32'(PRESCALE - 1) : 32'd0;

    logic [31:0] pre_cnt;

    assign tick = (pre_cnt == 32'd0);

    // Down-counter paces mtime; an mtime write restarts the period.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= 32'd0;
        end else if (wr_mtime || tick) begin
            pre_cnt <= RELOAD;
        end else begin
            pre_cnt <= pre_cnt - 32'd1;
        end
    end
`else
    localparam int unused_prescale = PRESCALE;

    assign tick = 1'b1;
`endif

    // mtime: a half-word write wins over the tick and freezes the other half.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime <= 64'd0;
        end else if (bus_we && sel_time_lo) begin
            mtime[31:0] <= bus_wdata;
        end else if (bus_we && sel_time_hi) begin
            mtime[63:32] <= bus_wdata;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // mtimecmp halves and msip are plain software-written registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtimecmp <= '1;
            msip     <= 1'b0;
        end else if (bus_we) begin
            if (sel_cmp_lo) mtimecmp[31:0]  <= bus_wdata;
            if (sel_cmp_hi) mtimecmp[63:32] <= bus_wdata;
            if (sel_msip)   msip            <= bus_wdata[0];
        end
    end

    // Registered bus response and interrupt vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_rdata <= 32'd0;
            bus_rvld  <= 1'b0;
            bus_err   <= 1'b0;
            intrpt    <= 32'd0;
        end else begin
            bus_rdata <= bus_re ? rd_mux : 32'd0;
            bus_rvld  <= bus_re;
            bus_err   <= illegal;
            intrpt    <= {24'd0, mtip_next, 3'd0, msip, 3'd0};
        end
    end

endmodule

// File: doc/otter_clint.md
# otter_clint

Machine-level timer and software-interrupt source for the Otter core: the producer side of the CSR interrupt inputs. It holds a 64-bit free-running `mtime`, a 64-bit `mtimecmp` compare register and a 1-bit `msip` register, all memory-mapped on a simple word-wide slave bus. It drives registered MTIP on bit 7 and MSIP on bit 3 of the `intrpt` vector consumed by the CSR unit; all other bits are tied to zero.

## Interface
- `PRESCALE`, 1: `mtime` tick period in clock cycles. Used only when `OTTER_CLINT_PRESCALER_EN` is defined; values 0 and 1 mean every cycle.
- `clk` input 1: sole clock; all state updates on posedge.
- `rst` input 1: synchronous, active-high reset.
- `bus_addr` input 16: byte offset within the CLINT window.
- `bus_wdata` input 32: write data.
- `bus_we` input 1: write strobe, single cycle, full-word only.
- `bus_re` input 1: read strobe, single cycle.
- `bus_rdata` output 32: read data, valid when `bus_rvld` is high, 0 otherwise.
- `bus_rvld` output 1: one-cycle pulse, one cycle after `bus_re`.
- `bus_err` output 1: one-cycle pulse, one cycle after an illegal access.
- `intrpt` output 32: bit 7 = MTIP, bit 3 = MSIP, all other bits 0.

## Operation
- Register map, word aligned:
  - 0x0000 `msip`: bit 0 is read/write; bits 31:1 read 0 and ignore writes.
  - 0x4000 `mtimecmp[31:0]`.
  - 0x4004 `mtimecmp[63:32]`.
  - 0xBFF8 `mtime[31:0]`.
  - 0xBFFC `mtime[63:32]`.
- Illegal access:
  - Any other address, or `bus_addr[1:0]` != 0, is illegal.
  - A write to an illegal address is dropped.
  - A read from an illegal address returns 0 with `bus_rvld`=1.
  - `bus_err`=1 the cycle after any illegal access.
- Tick: `mtime <= mtime + 1` as a full 64-bit add, carrying from the low word into the high word. 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
- Write/tick collision: a write to either `mtime` half replaces that half with `bus_wdata`. The other half keeps its current value, with no tick that cycle.
- `mtimecmp` halves are written independently. No hardware atomicity; software orders the writes.
- Comparison: `mtip_next = (mtime >= mtimecmp)`, a 64-bit unsigned compare using current register values. `intrpt[7]` registers `mtip_next`. `intrpt[3]` registers `msip[0]`.
- Simultaneous `bus_we` and `bus_re`:
  - The write is performed.
  - The read returns the pre-write value.
- Reads of `mtime` return the value before any same-cycle tick.
- Reset values:
  - `mtime`=0.
  - `mtimecmp`=0xFFFF_FFFF_FFFF_FFFF, so no MTIP out of reset.
  - `msip`=0, `intrpt`=0.
  - `bus_rdata`=0, `bus_rvld`=0, `bus_err`=0.
  - Prescale counter=0.
- `rst` mid-operation overrides every bus access and tick in that cycle.

## Timing
- Read latency: 1 cycle. `bus_rdata` and `bus_rvld` are registered and valid the cycle after `bus_re`.
- Writes take effect at the posedge where `bus_we` is sampled. A read issued the next cycle returns the new value.
- MTIP latency: `intrpt[7]` rises 1 cycle after the cycle in which `mtime >= mtimecmp` first holds. It falls 1 cycle after a `mtimecmp` or `mtime` write makes the compare false.
- MSIP latency: `intrpt[3]` follows `msip[0]` 1 cycle after the write cycle, so it is high 2 cycles after `bus_we` is asserted.
- No back-pressure: one access may be issued every cycle.

## Configuration
- `OTTER_CLINT_PRESCALER_EN` defined:
  - A down-counter reloads with `PRESCALE-1`.
  - `mtime` ticks only when the counter is 0.
  - Any `mtime` write also reloads the counter.
- Not defined:
  - `mtime` ticks every cycle not blocked by an `mtime` write.
  - `PRESCALE` is ignored and no counter logic is built.

## Test plan
- Reset:
  - Stimulus: assert `rst` for 2 cycles, release.
  - Response: read 0xBFF8 after 5 idle cycles returns 5 (immediately after release, 0); 0x4000 returns 0xFFFF_FFFF; `intrpt`=0.
- Carry:
  - Stimulus: write `mtime` lo=0xFFFF_FFFE, hi=0.
  - Response: 3 cycles later, read hi returns 1 and read lo returns 0 or 1, consistent with cycle count.
- Timer interrupt:
  - Stimulus: write `mtimecmp` hi=0 then lo=20 with `mtime` near 0.
  - Response: `intrpt[7]` rises exactly 1 cycle after `mtime`==20.
  - Then write `mtimecmp` lo=0xFFFF_FFFF; `intrpt[7]` falls the next cycle.
- Software interrupt:
  - Stimulus: write 0x0000=0xFFFF_FFFF.
  - Response: `intrpt[3]`=1 two cycles after the write; readback returns 0x1. Writing 0 clears `intrpt[3]` after 2 cycles.
- Illegal access:
  - Read 0x0010 → `bus_rdata`=0, `bus_rvld`=1, `bus_err`=1.
  - Write 0x4002 → `bus_err`=1, `mtimecmp` unchanged.
- Prescaler (with macro, `PRESCALE`=4):
  - Stimulus: write `mtime`=0, wait 16 cycles.
  - Response: read lo returns 4.
  - Without the macro, the same sequence returns 16.
